// File: rtl/bnn_fc_lane_mac.sv
`timescale 1ns/1ps
// Binary-weight MAC lane engine: per-beat signed lane sum, accumulated per group, two-stage pipe.
// Optional saturating accumulator when BNN_FC_SAT_EN is defined (default: two's-complement wrap).
module bnn_fc_lane_mac #(
  parameter int LANES     = 4,
  parameter int DW        = 9,
  parameter int ACC_W     = 24,
  parameter int MAX_BEATS = 1024,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*DW-1:0]    in_pix,
  input  logic [LANES-1:0]       in_w,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_acc,
  output logic [CNT_W-1:0]       out_beats,
  output logic                   out_ovf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  logic             rdy_reg;
  logic             en;
  logic             accept;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic             close;

  // rdy_reg keeps in_ready low until the first edge after reset release
  assign en      = ~out_valid | out_ready;
  assign in_ready = en & rdy_reg;
  assign accept  = in_valid & in_ready;
  assign cnt_inc = cnt_reg + 1'b1;
  assign close   = in_last | (cnt_inc == MAX_CNT);

  logic signed [DW:0] prod    [LANES];
  logic signed [DW:0] s1_prod [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [DW:0] ext;
    assign ext      = {in_pix[gi*DW + DW - 1], in_pix[gi*DW +: DW]};
    assign prod[gi] = in_w[gi] ? ext : -ext;
  end

  logic             s1_valid;
  logic             s1_first;
  logic             s1_last;
  logic [CNT_W-1:0] s1_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_reg  <= 1'b0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_cnt   <= '0;
      cnt_reg  <= '0;
      for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
    end else begin
      rdy_reg <= 1'b1;
      if (en) begin
        s1_valid <= accept;
        if (accept) begin
          for (int i = 0; i < LANES; i++) s1_prod[i] <= prod[i];
          s1_first <= (cnt_reg == '0);
          s1_last  <= close;
          s1_cnt   <= cnt_inc;
          cnt_reg  <= close ? '0 : cnt_inc;
        end
      end
    end
  end

  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] raw_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic                    ovf_reg;
  logic                    ovf_now;
  logic                    grp_ovf;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + {{(ACC_W-DW-1){s1_prod[i][DW]}}, s1_prod[i]};
  end

  // A first beat adds to zero, which is the same as loading the lane sum
  assign base    = s1_first ? '0 : acc_reg;
  assign raw_sum = base + lane_sum;
  assign ovf_now = (base[ACC_W-1] == lane_sum[ACC_W-1]) && (raw_sum[ACC_W-1] != base[ACC_W-1]);
  assign grp_ovf = (~s1_first & ovf_reg) | ovf_now;

`ifdef BNN_FC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  assign acc_next = ovf_now ? (lane_sum[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw_sum;
`else
  assign acc_next = raw_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (s1_valid) begin
        acc_reg <= acc_next;
        ovf_reg <= grp_ovf;
        if (s1_last) begin
          out_acc   <= acc_next;
          out_beats <= s1_cnt;
          out_ovf   <= grp_ovf;
        end
      end
      out_valid <= (s1_valid & s1_last) | (out_valid & ~out_ready);
    end
  end

endmodule
